// File: rtl/slot_arbiter_3bit.sv
// slot_arbiter_3bit
//   Four-requester round-robin arbiter with time-limited grant slots.
//   A grant lasts until the requester releases, the slot length expires or
//   abort_in forces it off. GAP_EN=1 inserts one idle turnaround cycle after
//   every grant; GAP_EN=0 re-arbitrates on the same edge the grant ends.
//
// Ports
//   clk          in   rising-edge clock
//   reset_al_in  in   asynchronous active-low reset
//   req_in[3:0]  in   level-sensitive requests
//   slot_len_in  in   slot length in cycles, 0 encodes 8 (captured at grant start)
//   abort_in     in   forced release of the current grant (ignored outside GRANT)
//   gnt_out[3:0] out  registered one-hot grant
//   busy_out     out  high while a grant is active
//   slot_cnt_out out  slot counter, 0 outside GRANT
//   expire_out   out  one-cycle pulse after a slot ran to its full length
module slot_arbiter_3bit #(
   parameter int unsigned GAP_EN = 1
) (
   input  logic       clk,
   input  logic       reset_al_in,
   input  logic [3:0] req_in,
   input  logic [2:0] slot_len_in,
   input  logic       abort_in,
   output logic [3:0] gnt_out,
   output logic       busy_out,
   output logic [2:0] slot_cnt_out,
   output logic       expire_out
);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   state_e     state_q;
   logic [3:0] gnt_q;
   logic [1:0] gnt_idx_q;
   logic [1:0] rr_ptr_q;
   logic [2:0] cnt_q;
   logic [2:0] slot_len_q;
   logic       expire_q;

   // Returns {found, index} of the first set request at or above ptr (mod 4).
   function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [2:0] res;
      res = 3'b000;
      // Descending scan so the smallest offset from ptr is written last.
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   logic [1:0] next_ptr;
   logic [2:0] arb_idle;
   logic [2:0] arb_rearb;
   logic [2:0] start_sel;
   logic       rel_hit;
   logic       exp_hit;
   logic       grant_end;

   always_comb begin
      next_ptr  = gnt_idx_q + 2'd1;
      arb_idle  = pick(req_in, rr_ptr_q);
      arb_rearb = pick(req_in, next_ptr);
      start_sel = (state_q == StGrant) ? arb_rearb : arb_idle;
      rel_hit   = ~req_in[gnt_idx_q];
      // slot_len_q of 0 means 8, and 0 - 1 wraps to 7, so one compare covers it.
      exp_hit   = (cnt_q == (slot_len_q - 3'd1));
      grant_end = abort_in | rel_hit | exp_hit;
   end

   always_ff @(posedge clk or negedge reset_al_in) begin
      if (!reset_al_in) begin
         state_q    <= StIdle;
         gnt_q      <= 4'b0000;
         gnt_idx_q  <= 2'd0;
         rr_ptr_q   <= 2'd0;
         cnt_q      <= 3'd0;
         slot_len_q <= 3'd0;
         expire_q   <= 1'b0;
      end else begin
         expire_q <= 1'b0;
         unique case (state_q)
            StIdle, StGap: begin
               if (start_sel[2]) begin
                  state_q    <= StGrant;
                  gnt_q      <= 4'b0001 << start_sel[1:0];
                  gnt_idx_q  <= start_sel[1:0];
                  cnt_q      <= 3'd0;
                  slot_len_q <= slot_len_in;
               end else begin
                  state_q <= StIdle;
                  gnt_q   <= 4'b0000;
                  cnt_q   <= 3'd0;
               end
            end
            StGrant: begin
               if (grant_end) begin
                  // Release and abort both suppress the expiry pulse.
                  expire_q <= exp_hit & ~rel_hit & ~abort_in;
                  rr_ptr_q <= next_ptr;
                  if (GAP_EN != 0) begin
                     state_q <= StGap;
                     gnt_q   <= 4'b0000;
                     cnt_q   <= 3'd0;
                  end else if (start_sel[2]) begin
                     state_q    <= StGrant;
                     gnt_q      <= 4'b0001 << start_sel[1:0];
                     gnt_idx_q  <= start_sel[1:0];
                     cnt_q      <= 3'd0;
                     slot_len_q <= slot_len_in;
                  end else begin
                     state_q <= StIdle;
                     gnt_q   <= 4'b0000;
                     cnt_q   <= 3'd0;
                  end
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               gnt_q   <= 4'b0000;
               cnt_q   <= 3'd0;
            end
         endcase
      end
   end

   assign gnt_out      = gnt_q;
   assign busy_out     = (state_q == StGrant);
   assign slot_cnt_out = cnt_q;
   assign expire_out   = expire_q;

endmodule

// File: tb/tb_slot_arbiter_3bit.sv
// Bench for slot_arbiter_3bit: one instance with GAP_EN=1 (index 0) and one
// with GAP_EN=0 (index 1) share all inputs. A behavioural model tracks, per
// instance, the current owner, cycles elapsed in the slot and the round-robin
// pointer; every clock both instances are compared against it. Directed
// scenarios add constant expectations on top.
module tb_slot_arbiter_3bit;

   logic       clk = 1'b0;
   logic       reset_al_in;
   logic [3:0] req_in;
   logic [2:0] slot_len_in;
   logic       abort_in;

   logic [3:0] gnt_g, gnt_n;
   logic       busy_g, busy_n;
   logic [2:0] cnt_g, cnt_n;
   logic       exp_g, exp_n;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state, index 0 = gap instance, 1 = no-gap instance.
   int m_owner   [2];
   int m_elapsed [2];
   int m_len     [2];
   int m_ptr     [2];
   bit m_expire  [2];

   always #5 clk = ~clk;

   slot_arbiter_3bit #(.GAP_EN(1)) u_gap (
      .clk          (clk),
      .reset_al_in  (reset_al_in),
      .req_in       (req_in),
      .slot_len_in  (slot_len_in),
      .abort_in     (abort_in),
      .gnt_out      (gnt_g),
      .busy_out     (busy_g),
      .slot_cnt_out (cnt_g),
      .expire_out   (exp_g)
   );

   slot_arbiter_3bit #(.GAP_EN(0)) u_nogap (
      .clk          (clk),
      .reset_al_in  (reset_al_in),
      .req_in       (req_in),
      .slot_len_in  (slot_len_in),
      .abort_in     (abort_in),
      .gnt_out      (gnt_n),
      .busy_out     (busy_n),
      .slot_cnt_out (cnt_n),
      .expire_out   (exp_n)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] want);
      n_checks++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, want);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k]   = -1;
         m_elapsed[k] = 0;
         m_len[k]     = 8;
         m_ptr[k]     = 0;
         m_expire[k]  = 1'b0;
      end
   endtask

   task automatic try_grant(input int k);
      for (int i = 0; i < 4; i++) begin
         int c;
         c = (m_ptr[k] + i) % 4;
         if (req_in[c]) begin
            m_owner[k]   = c;
            m_elapsed[k] = 0;
            m_len[k]     = (slot_len_in == 3'd0) ? 8 : int'(slot_len_in);
            return;
         end
      end
   endtask

   task automatic model_step(input int k, input bit gap_en);
      m_expire[k] = 1'b0;
      if (m_owner[k] >= 0) begin
         bit released, expired;
         released = !req_in[m_owner[k]];
         expired  = (m_elapsed[k] + 1 == m_len[k]);
         if (released || expired || abort_in) begin
            m_expire[k] = expired && !released && !abort_in;
            m_ptr[k]    = (m_owner[k] + 1) % 4;
            m_owner[k]  = -1;
            if (!gap_en) try_grant(k);
         end else begin
            m_elapsed[k]++;
         end
      end else begin
         try_grant(k);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         logic [3:0] o_gnt, w_gnt;
         logic       o_busy, o_exp;
         logic [2:0] o_cnt, w_cnt;
         o_gnt  = (k == 0) ? gnt_g  : gnt_n;
         o_busy = (k == 0) ? busy_g : busy_n;
         o_cnt  = (k == 0) ? cnt_g  : cnt_n;
         o_exp  = (k == 0) ? exp_g  : exp_n;
         w_gnt  = 4'b0000;
         w_cnt  = 3'd0;
         if (m_owner[k] >= 0) begin
            w_gnt[m_owner[k]] = 1'b1;
            w_cnt = 3'(m_elapsed[k]);
         end
         chk($sformatf("model_gnt[%0d]", k), o_gnt, w_gnt);
         chk($sformatf("model_busy[%0d]", k), {3'b000, o_busy}, {3'b000, m_owner[k] >= 0});
         chk($sformatf("model_cnt[%0d]", k), {1'b0, o_cnt}, {1'b0, w_cnt});
         chk($sformatf("model_expire[%0d]", k), {3'b000, o_exp}, {3'b000, m_expire[k]});
         chk($sformatf("onehot[%0d]", k), {3'b000, $countones(o_gnt) <= 1}, 4'b0001);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_al_in) begin
         model_step(0, 1'b1);
         model_step(1, 1'b0);
      end else begin
         model_reset();
      end
      #1;
      check_all();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt_g"}, gnt_g, 4'b0000);
      chk({tag, "_gnt_n"}, gnt_n, 4'b0000);
      chk({tag, "_misc"}, {busy_g, busy_n, exp_g, exp_n}, 4'b0000);
      chk({tag, "_cnt"}, {1'b0, cnt_g | cnt_n}, 4'b0000);
   endtask

   initial begin
      reset_al_in = 1'b0;
      req_in      = 4'b0000;
      slot_len_in = 3'd0;
      abort_in    = 1'b0;
      model_reset();
      tick();
      tick();
      chk_zero("reset");

      // Two requesters, L=3: 0010 for 3 cycles, expiry, gap, then 1000.
      reset_al_in = 1'b1;
      req_in      = 4'b1010;
      slot_len_in = 3'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s1_gnt", gnt_g, 4'b0010);
         chk("s1_cnt", {1'b0, cnt_g}, 4'(i));
      end
      tick();
      chk("s1_gap_gnt", gnt_g, 4'b0000);
      chk("s1_expire", {3'b000, exp_g}, 4'b0001);
      tick();
      chk("s1_next_gnt", gnt_g, 4'b1000);
      chk("s1_expire_done", {3'b000, exp_g}, 4'b0000);
      req_in = 4'b0000;
      tick();
      tick();
      tick();

      // L=8 (encoded 0); slot_len_in changed mid-slot must not matter.
      req_in      = 4'b0001;
      slot_len_in = 3'd0;
      tick();
      chk("s2_gnt", gnt_g, 4'b0001);
      slot_len_in = 3'd5;
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("s2_hold_gnt", gnt_g, 4'b0001);
         chk("s2_cnt", {1'b0, cnt_g}, 4'(i));
      end
      tick();
      chk("s2_gap_gnt", gnt_g, 4'b0000);
      chk("s2_expire", {3'b000, exp_g}, 4'b0001);
      tick();
      chk("s2_regrant", gnt_g, 4'b0001);
      req_in = 4'b0000;
      tick();
      tick();
      tick();

      // Requester 2, L=5, released at cnt=1; pointer then sits at 3.
      req_in = 4'b0100;
      tick();
      chk("s3_gnt", gnt_g, 4'b0100);
      tick();
      chk("s3_cnt", {1'b0, cnt_g}, 4'b0001);
      req_in = 4'b0000;
      tick();
      chk("s3_released", gnt_g, 4'b0000);
      chk("s3_no_expire", {3'b000, exp_g}, 4'b0000);
      tick();
      req_in      = 4'b1001;
      slot_len_in = 3'd4;
      tick();
      chk("s3_ptr3", gnt_g, 4'b1000);

      // Abort at cnt=1 of the L=4 grant; pointer advances to 0.
      tick();
      chk("s4_cnt", {1'b0, cnt_g}, 4'b0001);
      abort_in = 1'b1;
      tick();
      chk("s4_aborted", gnt_g, 4'b0000);
      chk("s4_no_expire", {3'b000, exp_g}, 4'b0000);
      abort_in    = 1'b0;
      req_in      = 4'b0001;
      slot_len_in = 3'd6;
      tick();
      chk("s4_ptr0", gnt_g, 4'b0001);

      // Asynchronous reset at cnt=3, then requester 2 after release.
      tick();
      tick();
      tick();
      chk("s5_cnt", {1'b0, cnt_g}, 4'b0011);
      reset_al_in = 1'b0;
      #1;
      model_reset();
      chk_zero("s5_async");
      tick();
      req_in      = 4'b0100;
      reset_al_in = 1'b1;
      tick();
      chk("s5_gnt_g", gnt_g, 4'b0100);
      chk("s5_gnt_n", gnt_n, 4'b0100);

      // Back-to-back rotation without gap, L=2, starting from requester 0.
      reset_al_in = 1'b0;
      req_in      = 4'b0000;
      tick();
      req_in      = 4'b1111;
      slot_len_in = 3'd2;
      reset_al_in = 1'b1;
      begin
         logic [3:0] rot [9];
         rot = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                 4'b1000, 4'b1000, 4'b0001};
         for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("s6_rot%0d", i), gnt_n, rot[i]);
            chk($sformatf("s6_busy%0d", i), {3'b000, busy_n}, 4'b0001);
         end
      end

      // Random traffic against the model, with occasional async resets.
      for (int it = 0; it < 800; it++) begin
         if ($urandom_range(0, 99) < 2) begin
            reset_al_in = 1'b0;
            #1;
            model_reset();
            chk_zero("rand_reset");
            reset_al_in = 1'b1;
         end
         if ($urandom_range(0, 3) == 0) req_in = 4'($urandom);
         slot_len_in = 3'($urandom);
         abort_in    = ($urandom_range(0, 9) == 0);
         tick();
      end
      abort_in = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/slot_arbiter_3bit.md
SLOT_ARBITER_3BIT -- requirements
Module: slot_arbiter_3bit

Interface
REQ-001 Parameter: GAP_EN, default 1, 1 inserts one idle turnaround cycle between consecutive grants, 0 allows back-to-back grants.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_al_in  input  1  reset, asynchronous, active-low.
REQ-004 req_in  input  4  per-requester access request, level-sensitive.
REQ-005 slot_len_in  input  3  grant slot length in cycles; 0 encodes 8.
REQ-006 abort_in  input  1  synchronous forced release of the current grant.
REQ-007 gnt_out  output  4  registered one-hot grant, all-zero when no grant.
REQ-008 busy_out  output  1  high while a grant is active.
REQ-009 slot_cnt_out  output  3  internal 3-bit slot counter value.
REQ-010 expire_out  output  1  one-cycle pulse marking a slot expiry.

Function
REQ-011 The block SHALL use an FSM with states IDLE, GRANT and GAP; only GRANT drives a nonzero gnt_out.
REQ-012 The slot timer SHALL be a 3-bit up counter, loaded with 0 on grant start and incremented by 1 each GRANT cycle, wrapping 7->0.
REQ-013 Arbitration SHALL be round-robin: the winner is the first asserted req_in bit scanning upward from rr_ptr (2-bit, modulo 4).
REQ-014 In IDLE or GAP, if any req_in bit is sampled high at an edge, gnt_out SHALL assert one-hot for the winner from that edge (1-cycle latency).
REQ-015 At grant start, slot_len_in SHALL be captured into slot_len_q; later changes SHALL not affect the active slot.
REQ-016 Slot length L SHALL be slot_len_q, or 8 when slot_len_q is 0.
REQ-017 The grant SHALL end at the edge where the granted req_in bit is sampled low (release).
REQ-018 The grant SHALL end at the edge where slot_cnt_out equals L-1 (expiry), so that a holding requester receives exactly L grant cycles.
REQ-019 On expiry, expire_out SHALL be high for exactly the one cycle following the last grant cycle.
REQ-020 The grant SHALL end at the edge where abort_in is sampled high during GRANT, with no expire_out pulse.
REQ-021 If release and expiry coincide, the end SHALL be treated as a release, with no expire_out pulse.
REQ-022 If abort_in coincides with expiry, abort SHALL take priority and produce no pulse.
REQ-023 On every grant end, rr_ptr SHALL become (granted index + 1) mod 4.
REQ-024 With GAP_EN=1, a grant end SHALL move to GAP for exactly one cycle, then arbitration per REQ-014 applies.
REQ-025 With GAP_EN=0, a grant end SHALL re-arbitrate in the same edge using the updated rr_ptr: GRANT if any req_in is high, else IDLE.
REQ-026 Under REQ-025, the just-released requester SHALL be eligible only if no other requester is high.
REQ-027 abort_in SHALL be ignored outside GRANT.
REQ-028 busy_out SHALL equal (state == GRANT).
REQ-029 slot_cnt_out SHALL read 0 in IDLE and GAP.
REQ-030 gnt_out SHALL never have more than one bit set.

Reset
REQ-031 While reset_al_in is low, the block SHALL asynchronously force: state IDLE, gnt_out=0000, busy_out=0, slot_cnt_out=000, expire_out=0, rr_ptr=0, slot_len_q=0.
REQ-032 A reset asserted mid-grant SHALL drop gnt_out immediately, without waiting for a clock edge, and SHALL not produce an expire_out pulse.
REQ-033 After reset release, the first arbitration SHALL favour requester 0.

Verification
REQ-034 The bench SHALL cover: reset release, req_in=1010, slot_len_in=3 held -> gnt_out=0010 for 3 cycles (cnt 0,1,2), expire_out pulse, GAP, then gnt_out=1000.
REQ-035 The bench SHALL cover: req_in=0001 held, slot_len_in=0 -> 8 grant cycles, cnt 0..7, expire pulse after cnt=7, regrant to 0001 after GAP.
REQ-036 The bench SHALL cover: grant to req 2 with L=5, req_in[2] dropped when cnt=1 -> gnt_out=0000 at next edge, no expire pulse, rr_ptr=3.
REQ-037 The bench SHALL cover: GAP_EN=0, req_in=1111, L=2 -> grants 0001,0010,0100,1000,0001, each 2 cycles, with no idle cycles between them.
REQ-038 The bench SHALL cover: abort_in pulsed at cnt=1 of an L=4 grant -> grant ends at next edge, no expire pulse, pointer advances.
REQ-039 The bench SHALL cover: reset_al_in low mid-grant at cnt=3 -> all outputs zero immediately; after release with req_in=0100 -> gnt_out=0100.
